wall_height_lfsr_gen: RTL

Parametrised pseudo-random wall-height source for the scrolling-wall game datapath.
- Fibonacci LFSR of configurable width and tap mask.
- Runs a fixed number of shifts per request, then folds the sample into [MIN_H, MAX_H] by sequential modulo.
- Presents the result on a valid/ready interface to the wall spawner.
- Supports runtime reseeding and lockup-free seeding.

---
 rtl/wall_height_lfsr_gen_if.sv | 33 +++
 rtl/wall_height_lfsr_gen.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/wall_height_lfsr_gen_if.sv
// ---------------------------------------------------------------------------
// wall_height_lfsr_gen_if
// Bundle between the wall-height generator and the wall spawner.
//   seed_load / seed_in : runtime reseed request and value
//   req                 : request a new height
//   height / height_valid / height_ready : valid/ready result channel
//   busy                : generator is shifting or mapping
//   lfsr_state          : live LFSR contents for debug / score display
// master = generator side, slave = spawner / driver side.
// ---------------------------------------------------------------------------
interface wall_height_lfsr_gen_if #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 7
);
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic             req;
  logic [OUT_W-1:0] height;
  logic             height_valid;
  logic             height_ready;
  logic             busy;
  logic [WIDTH-1:0] lfsr_state;

  modport master (
    input  seed_load, seed_in, req, height_ready,
    output height, height_valid, busy, lfsr_state
  );

  modport slave (
    output seed_load, seed_in, req, height_ready,
    input  height, height_valid, busy, lfsr_state
  );
endinterface

// File: rtl/wall_height_lfsr_gen.sv
// ---------------------------------------------------------------------------
// wall_height_lfsr_gen
// Pseudo-random wall-height source. A Fibonacci LFSR is stepped SHIFTS times
// per request, the sample is folded into [MIN_H, MAX_H] by repeated
// subtraction, and the result is offered on a valid/ready channel.
// Ports:
//   i_clk    : system clock, rising edge
//   i_resetn : asynchronous active-low reset
//   bus      : generator side of wall_height_lfsr_gen_if (see interface file)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for req
// ST_SHIFT | one LFSR step per cycle, SHIFTS steps in total
// ST_MAP   | subtract RANGE from acc until acc < RANGE, then emit height
// ST_VALID | height held until accepted by height_ready
// ---------------------------------------------------------------------------
module wall_height_lfsr_gen #(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(8'h5A),
  parameter int               SHIFTS = WIDTH,
  parameter int               OUT_W  = 7,
  parameter int               MIN_H  = 20,
  parameter int               MAX_H  = 90
) (
  input  logic                   i_clk,
  input  logic                   i_resetn,
  wall_height_lfsr_gen_if.master bus
);

  localparam int               CNT_W     = $clog2(SHIFTS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SHIFTS - 1);
  localparam logic [31:0]      RANGE     = 32'(MAX_H - MIN_H + 1);
  localparam logic [WIDTH-1:0] RANGE_ACC = RANGE[WIDTH-1:0];

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MAP   = 2'd2,
    ST_VALID = 2'd3
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_lfsr;
  logic [WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [OUT_W-1:0]   r_height;
  logic               r_valid;

  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_lfsr_nxt;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [OUT_W-1:0]   w_height_nxt;
  logic               w_valid_nxt;
  logic               w_fb;
  logic [WIDTH-1:0]   w_lfsr_step;
  logic               w_acc_ge;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state  <= ST_IDLE;
      r_lfsr   <= SEED;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_height <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_lfsr   <= w_lfsr_nxt;
      r_acc    <= w_acc_nxt;
      r_cnt    <= w_cnt_nxt;
      r_height <= w_height_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  always_comb begin
    w_fb         = ^(r_lfsr & TAPS);
    w_lfsr_step  = {r_lfsr[WIDTH-2:0], w_fb};
    // Compare in 32 bits so a RANGE wider than acc simply never matches.
    w_acc_ge     = ({{(32-WIDTH){1'b0}}, r_acc} >= RANGE);

    w_state_nxt  = r_state;
    w_lfsr_nxt   = r_lfsr;
    w_acc_nxt    = r_acc;
    w_cnt_nxt    = r_cnt;
    w_height_nxt = r_height;
    w_valid_nxt  = r_valid;

    case (r_state)
      ST_IDLE: begin
        if (bus.req) begin
          w_state_nxt = ST_SHIFT;
          w_cnt_nxt   = '0;
        end
      end
      ST_SHIFT: begin
        w_lfsr_nxt = w_lfsr_step;
        w_cnt_nxt  = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_LAST) begin
          w_acc_nxt   = w_lfsr_step;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_MAP;
        end
      end
      ST_MAP: begin
        if (w_acc_ge) begin
          w_acc_nxt = r_acc - RANGE_ACC;
        end else begin
          // acc < RANGE here, so the sum stays within OUT_W bits.
          w_height_nxt = OUT_W'(MIN_H) + OUT_W'(r_acc);
          w_valid_nxt  = 1'b1;
          w_state_nxt  = ST_VALID;
        end
      end
      ST_VALID: begin
        if (bus.height_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Reseed overrides any activity; a zero seed would lock the LFSR.
    if (bus.seed_load) begin
      w_lfsr_nxt  = (bus.seed_in == '0) ? SEED : bus.seed_in;
      w_state_nxt = ST_IDLE;
      w_valid_nxt = 1'b0;
      w_cnt_nxt   = '0;
    end
  end

  assign bus.height       = r_height;
  assign bus.height_valid = r_valid;
  assign bus.busy         = (r_state == ST_SHIFT) || (r_state == ST_MAP);
  assign bus.lfsr_state   = r_lfsr;

endmodule
